// File: rtl/enigma_pkg.sv
// Shared Enigma constants: letter indices, wiring tables, notches and modular helpers.
package enigma_pkg;

    typedef logic [4:0] letter_t;

    localparam letter_t LtrA = 5'd0,  LtrB = 5'd1,  LtrC = 5'd2,  LtrD = 5'd3,  LtrE = 5'd4;
    localparam letter_t LtrF = 5'd5,  LtrG = 5'd6,  LtrH = 5'd7,  LtrI = 5'd8,  LtrJ = 5'd9;
    localparam letter_t LtrK = 5'd10, LtrL = 5'd11, LtrM = 5'd12, LtrN = 5'd13, LtrO = 5'd14;
    localparam letter_t LtrP = 5'd15, LtrQ = 5'd16, LtrR = 5'd17, LtrS = 5'd18, LtrT = 5'd19;
    localparam letter_t LtrU = 5'd20, LtrV = 5'd21, LtrW = 5'd22, LtrX = 5'd23, LtrY = 5'd24;
    localparam letter_t LtrZ = 5'd25;

    typedef enum logic [1:0] {
        CfgI   = 2'b00,
        CfgII  = 2'b01,
        CfgIII = 2'b10,
        CfgId  = 2'b11
    } rotor_cfg_e;

    typedef enum logic [1:0] {StIdle, StStep, StMap} state_e;

    localparam letter_t NotchI = LtrQ, NotchII = LtrE, NotchIII = LtrV;

    localparam letter_t RotIFwd [26] = '{LtrE, LtrK, LtrM, LtrF, LtrL, LtrG, LtrD, LtrQ, LtrV,
        LtrZ, LtrN, LtrT, LtrO, LtrW, LtrY, LtrH, LtrX, LtrU, LtrS, LtrP, LtrA, LtrI, LtrB, LtrR,
        LtrC, LtrJ};
    localparam letter_t RotIInv [26] = '{LtrU, LtrW, LtrY, LtrG, LtrA, LtrD, LtrF, LtrP, LtrV,
        LtrZ, LtrB, LtrE, LtrC, LtrK, LtrM, LtrT, LtrH, LtrX, LtrS, LtrL, LtrR, LtrI, LtrN, LtrQ,
        LtrO, LtrJ};
    localparam letter_t RotIIFwd [26] = '{LtrA, LtrJ, LtrD, LtrK, LtrS, LtrI, LtrR, LtrU, LtrX,
        LtrB, LtrL, LtrH, LtrW, LtrT, LtrM, LtrC, LtrQ, LtrG, LtrZ, LtrN, LtrP, LtrY, LtrF, LtrV,
        LtrO, LtrE};
    localparam letter_t RotIIInv [26] = '{LtrA, LtrJ, LtrP, LtrC, LtrZ, LtrW, LtrR, LtrL, LtrF,
        LtrB, LtrD, LtrK, LtrO, LtrT, LtrY, LtrU, LtrQ, LtrG, LtrE, LtrN, LtrH, LtrX, LtrM, LtrI,
        LtrV, LtrS};
    localparam letter_t RotIIIFwd [26] = '{LtrB, LtrD, LtrF, LtrH, LtrJ, LtrL, LtrC, LtrP, LtrR,
        LtrT, LtrX, LtrV, LtrZ, LtrN, LtrY, LtrE, LtrI, LtrW, LtrG, LtrA, LtrK, LtrM, LtrU, LtrS,
        LtrQ, LtrO};
    localparam letter_t RotIIIInv [26] = '{LtrT, LtrA, LtrG, LtrB, LtrP, LtrC, LtrS, LtrD, LtrQ,
        LtrE, LtrU, LtrF, LtrV, LtrN, LtrZ, LtrH, LtrY, LtrI, LtrX, LtrJ, LtrW, LtrL, LtrR, LtrK,
        LtrO, LtrM};
    localparam letter_t UkwB [26] = '{LtrY, LtrR, LtrU, LtrH, LtrQ, LtrS, LtrL, LtrD, LtrP,
        LtrX, LtrN, LtrG, LtrO, LtrK, LtrM, LtrI, LtrE, LtrB, LtrF, LtrZ, LtrC, LtrW, LtrV, LtrJ,
        LtrA, LtrT};

    function automatic letter_t mod26_add(letter_t a, letter_t b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        return s[4:0];
    endfunction

    function automatic letter_t mod26_sub(letter_t a, letter_t b);
        logic [5:0] s;
        s = {1'b0, a} - {1'b0, b};
        if (a < b) s = s + 6'd26;
        return s[4:0];
    endfunction

    function automatic logic at_notch(logic [1:0] cfg, letter_t pos);
        logic hit;
        unique case (cfg)
            CfgI:    hit = (pos == NotchI);
            CfgII:   hit = (pos == NotchII);
            CfgIII:  hit = (pos == NotchIII);
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/rotor_map.sv
// One rotor pass: ring/position offset, wiring lookup (forward or inverse), offset removal.
module rotor_map
    import enigma_pkg::*;
(
    input  logic [4:0] idx_i,
    input  logic [4:0] pos_i,
    input  logic [4:0] ring_i,
    input  logic [1:0] cfg_i,
    input  logic       rev_i,
    output logic [4:0] idx_o
);

    letter_t contact;
    letter_t wired;

    always_comb begin
        contact = mod26_sub(mod26_add(idx_i, pos_i), ring_i);
        wired   = contact;
        unique case (cfg_i)
            CfgI:    wired = rev_i ? RotIInv[contact]   : RotIFwd[contact];
            CfgII:   wired = rev_i ? RotIIInv[contact]  : RotIIFwd[contact];
            CfgIII:  wired = rev_i ? RotIIIInv[contact] : RotIIIFwd[contact];
            default: wired = contact;
        endcase
        idx_o = mod26_add(mod26_sub(wired, pos_i), ring_i);
    end

endmodule

// File: rtl/rotor_bank.sv
// Enigma scrambler: rotor stack with stepping/double-stepping, UKW-B reflector, key handshake.
module rotor_bank
    import enigma_pkg::*;
#(
    parameter int unsigned NUM_ROTORS = 3,
    parameter int unsigned IDX_W      = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_valid,
    input  logic [NUM_ROTORS*IDX_W-1:0]   load_pos,
    input  logic [NUM_ROTORS*IDX_W-1:0]   load_ring,
    input  logic [NUM_ROTORS*2-1:0]       load_cfg,
    input  logic                          key_valid,
    input  logic [25:0]                   key_in,
    output logic                          key_ready,
    output logic                          out_valid,
    output logic [25:0]                   out_letter,
    output logic                          out_err,
    output logic [NUM_ROTORS*IDX_W-1:0]   positions
);

    state_e                        state_q, state_d;
    logic [NUM_ROTORS*IDX_W-1:0]   pos_q, pos_d, ring_q, ring_d, pos_step;
    logic [NUM_ROTORS*2-1:0]       cfg_q, cfg_d;
    logic [25:0]                   key_q, key_d, letter_q, letter_d;
    logic                          valid_q, valid_d, err_q, err_d;
    logic                          key_onehot;
    letter_t                       key_idx, refl_idx, result_idx;

    always_comb begin
        key_onehot = (key_q != '0) && ((key_q & (key_q - 26'd1)) == '0);
        key_idx    = '0;
        for (int i = 0; i < 26; i++) begin
            if (key_q[i]) key_idx = key_idx | letter_t'(i);
        end
    end

    // Stepping decisions all look at pre-step positions; the map chain uses current positions.
    for (genvar i = 0; i < NUM_ROTORS; i++) begin : g_rotor
        letter_t fwd_in, fwd_out, rev_in, rev_out;
        logic    step;

        if (i == 0) begin : g_fast
            assign step = 1'b1;
        end else if (i + 1 < NUM_ROTORS) begin : g_middle
            assign step = at_notch(cfg_q[2*(i-1) +: 2], pos_q[IDX_W*(i-1) +: IDX_W])
                        | at_notch(cfg_q[2*i +: 2], pos_q[IDX_W*i +: IDX_W]);
        end else begin : g_slow
            assign step = at_notch(cfg_q[2*(i-1) +: 2], pos_q[IDX_W*(i-1) +: IDX_W]);
        end

        assign pos_step[IDX_W*i +: IDX_W] = step ? mod26_add(pos_q[IDX_W*i +: IDX_W], 5'd1)
                                                 : pos_q[IDX_W*i +: IDX_W];

        if (i == 0) begin : g_fwd_first
            assign fwd_in = key_idx;
        end else begin : g_fwd_chain
            assign fwd_in = g_rotor[i-1].fwd_out;
        end

        if (i == NUM_ROTORS - 1) begin : g_rev_first
            assign rev_in = refl_idx;
        end else begin : g_rev_chain
            assign rev_in = g_rotor[i+1].rev_out;
        end

        rotor_map u_fwd (
            .idx_i  (fwd_in),
            .pos_i  (pos_q[IDX_W*i +: IDX_W]),
            .ring_i (ring_q[IDX_W*i +: IDX_W]),
            .cfg_i  (cfg_q[2*i +: 2]),
            .rev_i  (1'b0),
            .idx_o  (fwd_out)
        );

        rotor_map u_rev (
            .idx_i  (rev_in),
            .pos_i  (pos_q[IDX_W*i +: IDX_W]),
            .ring_i (ring_q[IDX_W*i +: IDX_W]),
            .cfg_i  (cfg_q[2*i +: 2]),
            .rev_i  (1'b1),
            .idx_o  (rev_out)
        );
    end

    assign refl_idx   = UkwB[g_rotor[NUM_ROTORS-1].fwd_out];
    assign result_idx = g_rotor[0].rev_out;

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        ring_d   = ring_q;
        cfg_d    = cfg_q;
        key_d    = key_q;
        letter_d = letter_q;
        valid_d  = 1'b0;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (load_valid) begin
                    pos_d  = load_pos;
                    ring_d = load_ring;
                    cfg_d  = load_cfg;
                end else if (key_valid) begin
                    key_d   = key_in;
                    state_d = StStep;
                end
            end
            StStep: begin
                pos_d   = pos_step;
                state_d = StMap;
            end
            StMap: begin
                valid_d  = 1'b1;
                err_d    = !key_onehot;
                letter_d = key_onehot ? (26'd1 << result_idx) : '0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            pos_q    <= '0;
            ring_q   <= '0;
            cfg_q    <= '1;
            key_q    <= '0;
            letter_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            ring_q   <= ring_d;
            cfg_q    <= cfg_d;
            key_q    <= key_d;
            letter_q <= letter_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign key_ready  = (state_q == StIdle) && !reset;
    assign out_valid  = valid_q;
    assign out_letter = letter_q;
    assign out_err    = err_q;
    assign positions  = pos_q;

endmodule

// File: tb/tb_rotor_bank.sv
// Scoreboard bench for rotor_bank against a string-table Enigma model.
module tb_rotor_bank;

    localparam int N = 3;
    localparam int W = 5;

    logic               clk = 1'b0;
    logic               reset, load_valid, key_valid;
    logic [N*W-1:0]     load_pos, load_ring, positions;
    logic [2*N-1:0]     load_cfg;
    logic [25:0]        key_in, out_letter;
    logic               key_ready, out_valid, out_err;

    always #5 clk = ~clk;

    rotor_bank #(.NUM_ROTORS(N), .IDX_W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_pos   (load_pos),
        .load_ring  (load_ring),
        .load_cfg   (load_cfg),
        .key_valid  (key_valid),
        .key_in     (key_in),
        .key_ready  (key_ready),
        .out_valid  (out_valid),
        .out_letter (out_letter),
        .out_err    (out_err),
        .positions  (positions)
    );

    typedef struct {
        logic [25:0] letter;
        logic        err;
    } exp_t;

    exp_t  exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    mpos[N];
    int    mring[N];
    int    mcfg[N];
    string refl_s  = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    string notch_s = "QEV";

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic int wire_fwd(int cfg, int c);
        string s;
        case (cfg)
            0:       s = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
            1:       s = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
            2:       s = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
            default: return c;
        endcase
        return int'(s[c]) - 65;
    endfunction

    function automatic int wire_inv(int cfg, int c);
        for (int j = 0; j < 26; j++) if (wire_fwd(cfg, j) == c) return j;
        return -1;
    endfunction

    function automatic bit notch(int cfg, int p);
        if (cfg > 2) return 1'b0;
        return p == int'(notch_s[cfg]) - 65;
    endfunction

    function automatic void model_step();
        int  old[N];
        bit  st;
        old = mpos;
        for (int i = 0; i < N; i++) begin
            st = (i == 0);
            if (i > 0) begin
                if (notch(mcfg[i-1], old[i-1])) st = 1'b1;
                if (i < N - 1 && notch(mcfg[i], old[i])) st = 1'b1;
            end
            if (st) mpos[i] = (old[i] + 1) % 26;
        end
    endfunction

    function automatic int model_encrypt(int x_in);
        int x, c;
        x = x_in;
        for (int i = 0; i < N; i++) begin
            c = (x + mpos[i] - mring[i] + 26) % 26;
            x = (wire_fwd(mcfg[i], c) - mpos[i] + mring[i] + 26) % 26;
        end
        x = int'(refl_s[x]) - 65;
        for (int i = N - 1; i >= 0; i--) begin
            c = (x + mpos[i] - mring[i] + 26) % 26;
            x = (wire_inv(mcfg[i], c) - mpos[i] + mring[i] + 26) % 26;
        end
        return x;
    endfunction

    function automatic logic [N*W-1:0] model_pos();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(mpos[i]);
        return v;
    endfunction

    // Leftmost character of the string is the slowest rotor.
    function automatic logic [N*W-1:0] str_pos(string s);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(int'(s[N-1-i]) - 65);
        return v;
    endfunction

    function automatic logic [25:0] oh(int idx);
        return 26'd1 << idx;
    endfunction

    // Scoreboard monitor: every DUT result must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected out_valid: got letter %0h, expected no output", out_letter);
            end else begin
                e = exp_q.pop_front();
                check("out_letter", out_letter, e.letter);
                check("out_err", out_err, e.err);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (key_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (key_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL key_ready wait: got %b expected 1", key_ready);
        end
    endtask

    task automatic do_load(input logic [N*W-1:0] p, input logic [N*W-1:0] r,
                           input logic [2*N-1:0] c);
        wait_ready();
        load_valid = 1'b1;
        load_pos   = p;
        load_ring  = r;
        load_cfg   = c;
        @(posedge clk); #1;
        load_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            mpos[i]  = int'(p[i*W +: W]);
            mring[i] = int'(r[i*W +: W]);
            mcfg[i]  = int'(c[2*i +: 2]);
        end
        check("load positions", positions, p);
    endtask

    // use_const selects a fixed expected letter instead of the model's answer.
    task automatic send_key(input logic [25:0] k, input bit use_const, input logic [25:0] want,
                            output logic [25:0] got);
        exp_t e;
        wait_ready();
        model_step();
        if ($countones(k) != 1) begin
            e.letter = '0;
            e.err    = 1'b1;
        end else begin
            e.letter = use_const ? want : oh(model_encrypt($clog2(k)));
            e.err    = 1'b0;
        end
        got = e.letter;
        exp_q.push_back(e);
        key_valid = 1'b1;
        key_in    = k;
        @(posedge clk); #1;
        key_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("positions after key", positions, model_pos());
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mpos[i]  = 0;
            mring[i] = 0;
            mcfg[i]  = 3;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [25:0]    got, rec, k;
        logic [N*W-1:0] p, r;
        logic [2*N-1:0] c;
        string          s;
        int             p0;

        reset = 1'b1; load_valid = 1'b0; key_valid = 1'b0;
        load_pos = '0; load_ring = '0; load_cfg = '0; key_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset key_ready", key_ready, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_letter", out_letter, 0);
        check("reset positions", positions, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready after reset", key_ready, 1);

        // Rotors I-II-III (slow to fast), AAA, AAAAA
        do_load('0, '0, {2'b00, 2'b01, 2'b10});
        s = "BDZGO";
        for (int i = 0; i < 5; i++) send_key(oh(0), 1'b1, oh(int'(s[i]) - 65), got);

        do_load(str_pos("ADU"), '0, {2'b00, 2'b01, 2'b10});
        send_key(oh(7), 1'b0, '0, got);
        check("double step 1", positions, str_pos("ADV"));
        send_key(oh(11), 1'b0, '0, got);
        check("double step 2", positions, str_pos("AEW"));
        send_key(oh(2), 1'b0, '0, got);
        check("double step 3", positions, str_pos("BFX"));

        p = '0;
        r = '0;
        for (int i = 0; i < N; i++) begin
            p[i*W +: W] = W'($urandom_range(0, 25));
            r[i*W +: W] = W'($urandom_range(0, 25));
        end
        p[W-1:0] = 5'd25;
        do_load(p, r, '1);
        send_key(oh(0), 1'b1, oh(24), got);
        check("identity wrap Z->A", positions[W-1:0], 0);
        send_key(oh(24), 1'b1, oh(0), got);

        do_load('0, {5'd1, 5'd1, 5'd1}, {2'b00, 2'b01, 2'b10});
        send_key(oh(0), 1'b1, oh(4), got);

        do_load('0, {5'd0, 5'd0, 5'd1}, {2'b00, 2'b01, 2'b10});
        send_key(oh(0), 1'b0, '0, rec);
        do_load('0, {5'd0, 5'd0, 5'd1}, {2'b00, 2'b01, 2'b10});
        send_key(rec, 1'b1, oh(0), got);

        p0 = mpos[0];
        send_key(26'd0, 1'b0, '0, got);
        check("error key steps rotor0", positions[W-1:0], (p0 + 1) % 26);

        // Load and key together: load wins, no keypress taken
        wait_ready();
        p = str_pos("KMQ");
        load_valid = 1'b1; load_pos = p; load_ring = '0; load_cfg = {2'b10, 2'b00, 2'b01};
        key_valid = 1'b1; key_in = oh(0);
        @(posedge clk); #1;
        load_valid = 1'b0; key_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            mpos[i] = int'(p[i*W +: W]); mring[i] = 0; mcfg[i] = int'(load_cfg[2*i +: 2]);
        end
        check("load over key positions", positions, p);
        check("load over key ready", key_ready, 1);
        repeat (4) @(posedge clk);
        #1;
        check("load over key no step", positions, p);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < N; i++) begin
                    p[i*W +: W] = W'($urandom_range(0, 25));
                    r[i*W +: W] = W'($urandom_range(0, 25));
                    c[2*i +: 2] = 2'($urandom_range(0, 3));
                end
                do_load(p, r, c);
            end
            if ($urandom_range(0, 9) == 0) begin
                k = 26'($urandom);
                if ($countones(k) == 1) k = k | 26'd3;
            end else begin
                k = oh($urandom_range(0, 25));
            end
            send_key(k, 1'b0, '0, got);
        end

        // Reset while the key is in MAP: result must be dropped
        wait_ready();
        key_valid = 1'b1; key_in = oh(3);
        @(posedge clk); #1;
        key_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort out_valid", out_valid, 0);
        check("abort positions", positions, 0);
        check("abort key_ready", key_ready, 0);
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check("ready after abort", key_ready, 1);
        send_key(oh(0), 1'b1, oh(24), got);

        repeat (5) @(posedge clk);
        #1;
        check("pending expectations", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
